// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control chain: condition codes, NZCV bit
// positions and the per-stage control bundles.
package pipe_ctrl_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Raw decode bundle as held in Execute, before condition gating.
  typedef struct packed {
    logic       valid;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       nowrite;
    logic       branch;
    logic [1:0] flagw;
    cond_e      cond;
  } dec_ctrl_t;

  // Downstream stages only carry the already-gated controls.
  typedef struct packed {
    logic valid;
    logic pcs;
    logic regw;
    logic memw;
    logic memtoreg;
  } stg_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_chain_cond_check.sv
// Combinational condition-code evaluation against an NZCV flag set.
module cond_check
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      CC_EQ: pass = z;
      CC_NE: pass = ~z;
      CC_CS: pass = c;
      CC_CC: pass = ~c;
      CC_MI: pass = n;
      CC_PL: pass = ~n;
      CC_VS: pass = v;
      CC_VC: pass = ~v;
      CC_HI: pass = c & ~z;
      CC_LS: pass = ~c | z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = ~z & (n == v);
      CC_LE: pass = z | (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control-signal pipeline from Execute to Writeback with per-stage stall/flush,
// conditional-execution gating in Execute and the architectural NZCV register.
module pipe_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTG = 3,
  parameter int PW   = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic                 d_pcs,
  input  logic                 d_regw,
  input  logic                 d_memw,
  input  logic                 d_memtoreg,
  input  logic                 d_nowrite,
  input  logic                 d_branch,
  input  logic [1:0]           d_flagw,
  input  logic [3:0]           d_cond,
  input  logic [PW-1:0]        d_payload,
  input  logic [3:0]           alu_flags,
  input  logic [NSTG-1:0]      stall,
  input  logic [NSTG-1:0]      flush,
  output logic [NSTG-1:0]      s_valid,
  output logic [NSTG-1:0]      s_regw,
  output logic [NSTG-1:0]      s_memw,
  output logic [NSTG-1:0]      s_memtoreg,
  output logic [NSTG-1:0]      s_pcs,
  output logic [NSTG*PW-1:0]   s_payload,
  output logic                 branch_taken_e,
  output logic [3:0]           flags_q,
  output logic                 pc_write_inflight
);

  dec_ctrl_t     s0_q, s0_d, dec_in;
  stg_ctrl_t     up_q [1:NSTG-1];
  stg_ctrl_t     up_d [1:NSTG-1];
  logic [PW-1:0] pay_q [NSTG];
  logic [PW-1:0] pay_d [NSTG];
  logic [3:0]    flags_d;
  logic          pass0;
  logic          flag_upd;

  cond_check u_cond_check (
    .cond (s0_q.cond),
    .nzcv (flags_q),
    .pass (pass0)
  );

  // Stage outputs: Execute gates live against flags_q, later stages are pre-gated.
  always_comb begin
    s_valid    = '0;
    s_regw     = '0;
    s_memw     = '0;
    s_memtoreg = '0;
    s_pcs      = '0;
    s_payload  = '0;
    s_valid[0]    = s0_q.valid;
    s_regw[0]     = s0_q.regw & pass0 & ~s0_q.nowrite & s0_q.valid;
    s_memw[0]     = s0_q.memw & pass0 & s0_q.valid;
    s_pcs[0]      = s0_q.pcs & pass0 & s0_q.valid;
    s_memtoreg[0] = s0_q.memtoreg & s0_q.valid;
    s_payload[0 +: PW] = pay_q[0] & {PW{s0_q.valid}};
    for (int k = 1; k < NSTG; k++) begin
      s_valid[k]    = up_q[k].valid;
      s_regw[k]     = up_q[k].regw & up_q[k].valid;
      s_memw[k]     = up_q[k].memw & up_q[k].valid;
      s_pcs[k]      = up_q[k].pcs & up_q[k].valid;
      s_memtoreg[k] = up_q[k].memtoreg & up_q[k].valid;
      s_payload[k*PW +: PW] = pay_q[k] & {PW{up_q[k].valid}};
    end
  end

  assign branch_taken_e    = s0_q.valid & s0_q.branch & pass0;
  assign pc_write_inflight = (d_pcs & d_valid) | (|s_pcs[NSTG-2:0]);

  always_comb begin
    dec_in = '0;
    if (d_valid) begin
      dec_in.valid    = 1'b1;
      dec_in.pcs      = d_pcs;
      dec_in.regw     = d_regw;
      dec_in.memw     = d_memw;
      dec_in.memtoreg = d_memtoreg;
      dec_in.nowrite  = d_nowrite;
      dec_in.branch   = d_branch;
      dec_in.flagw    = d_flagw;
      dec_in.cond     = cond_e'(d_cond);
    end
  end

  always_comb begin
    s0_d     = s0_q;
    pay_d[0] = pay_q[0];
    if (flush[0]) begin
      s0_d     = '0;
      pay_d[0] = '0;
    end else if (!stall[0]) begin
      s0_d     = dec_in;
      pay_d[0] = d_valid ? d_payload : '0;
    end

    for (int k = 1; k < NSTG; k++) begin
      up_d[k]  = up_q[k];
      pay_d[k] = pay_q[k];
      // A stalled upstream stage leaves a bubble behind a free-running downstream one.
      if (flush[k] || (!stall[k] && stall[k-1])) begin
        up_d[k]  = '0;
        pay_d[k] = '0;
      end else if (!stall[k]) begin
        up_d[k].valid    = s_valid[k-1];
        up_d[k].pcs      = s_pcs[k-1];
        up_d[k].regw     = s_regw[k-1];
        up_d[k].memw     = s_memw[k-1];
        up_d[k].memtoreg = s_memtoreg[k-1];
        pay_d[k]         = s_payload[(k-1)*PW +: PW];
      end
    end
  end

  always_comb begin
    flags_d  = flags_q;
    flag_upd = s0_q.valid & pass0 & ~stall[0] & ~flush[0];
    if (flag_upd && s0_q.flagw[1]) flags_d[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
    if (flag_upd && s0_q.flagw[0]) flags_d[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q    <= '0;
      flags_q <= '0;
      for (int k = 1; k < NSTG; k++) up_q[k] <= '0;
      for (int k = 0; k < NSTG; k++) pay_q[k] <= '0;
    end else begin
      s0_q    <= s0_d;
      flags_q <= flags_d;
      for (int k = 1; k < NSTG; k++) up_q[k] <= up_d[k];
      for (int k = 0; k < NSTG; k++) pay_q[k] <= pay_d[k];
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed and random checks of pipe_ctrl_chain against an instruction-level model.
module tb_pipe_ctrl_chain;

  localparam int NSTG = 3;
  localparam int PW   = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic                d_valid, d_pcs, d_regw, d_memw, d_memtoreg, d_nowrite, d_branch;
  logic [1:0]          d_flagw;
  logic [3:0]          d_cond;
  logic [PW-1:0]       d_payload;
  logic [3:0]          alu_flags;
  logic [NSTG-1:0]     stall, flush;
  logic [NSTG-1:0]     s_valid, s_regw, s_memw, s_memtoreg, s_pcs;
  logic [NSTG*PW-1:0]  s_payload;
  logic                branch_taken_e;
  logic [3:0]          flags_q;
  logic                pc_write_inflight;

  always #5 clk = ~clk;

  pipe_ctrl_chain #(.NSTG(NSTG), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_pcs(d_pcs), .d_regw(d_regw), .d_memw(d_memw),
    .d_memtoreg(d_memtoreg), .d_nowrite(d_nowrite), .d_branch(d_branch),
    .d_flagw(d_flagw), .d_cond(d_cond), .d_payload(d_payload),
    .alu_flags(alu_flags), .stall(stall), .flush(flush),
    .s_valid(s_valid), .s_regw(s_regw), .s_memw(s_memw), .s_memtoreg(s_memtoreg),
    .s_pcs(s_pcs), .s_payload(s_payload), .branch_taken_e(branch_taken_e),
    .flags_q(flags_q), .pc_write_inflight(pc_write_inflight)
  );

  // One in-flight instruction; pass is frozen once it leaves Execute.
  typedef struct {
    bit          valid, pcs, regw, memw, mtr, nw, br;
    bit [1:0]    fw;
    bit [3:0]    cond;
    bit [PW-1:0] pay;
    bit          pass;
  } ins_t;

  ins_t     m [NSTG];
  bit [3:0] m_flags;
  int       total = 0;
  int       bad   = 0;

  function automatic bit cond_ok(bit [3:0] c, bit [3:0] f);
    bit n = f[3], z = f[2], cf = f[1], v = f[0];
    bit base = 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model_edge();
    ins_t old [NSTG];
    bit   p0;
    old = m;
    p0  = cond_ok(old[0].cond, m_flags);
    if (reset) begin
      foreach (m[k]) m[k] = '{default: 0};
      m_flags = 4'b0000;
      return;
    end
    if (old[0].valid && p0 && !stall[0] && !flush[0]) begin
      if (old[0].fw[1]) m_flags[3:2] = alu_flags[3:2];
      if (old[0].fw[0]) m_flags[1:0] = alu_flags[1:0];
    end
    for (int k = 0; k < NSTG; k++) begin
      if (flush[k]) m[k] = '{default: 0};
      else if (stall[k]) m[k] = old[k];
      else if (k == 0) begin
        m[0] = '{default: 0};
        if (d_valid) begin
          m[0].valid = 1; m[0].pcs = d_pcs; m[0].regw = d_regw; m[0].memw = d_memw;
          m[0].mtr = d_memtoreg; m[0].nw = d_nowrite; m[0].br = d_branch;
          m[0].fw = d_flagw; m[0].cond = d_cond; m[0].pay = d_payload;
        end
      end else if (stall[k-1]) m[k] = '{default: 0};
      else begin
        m[k] = old[k-1];
        if (k == 1) m[k].pass = p0;
      end
    end
  endtask

  task automatic cmp(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [NSTG-1:0]    ev, er, em, et, ep;
    logic [NSTG*PW-1:0] epay;
    bit                 ps;
    ev = '0; er = '0; em = '0; et = '0; ep = '0; epay = '0;
    for (int k = 0; k < NSTG; k++) begin
      ps    = (k == 0) ? cond_ok(m[0].cond, m_flags) : m[k].pass;
      ev[k] = m[k].valid;
      er[k] = m[k].valid && m[k].regw && !m[k].nw && ps;
      em[k] = m[k].valid && m[k].memw && ps;
      et[k] = m[k].valid && m[k].mtr;
      ep[k] = m[k].valid && m[k].pcs && ps;
      if (m[k].valid) epay[k*PW +: PW] = m[k].pay;
    end
    cmp({tag, ".valid"}, 64'(s_valid), 64'(ev));
    cmp({tag, ".regw"}, 64'(s_regw), 64'(er));
    cmp({tag, ".memw"}, 64'(s_memw), 64'(em));
    cmp({tag, ".memtoreg"}, 64'(s_memtoreg), 64'(et));
    cmp({tag, ".pcs"}, 64'(s_pcs), 64'(ep));
    cmp({tag, ".payload"}, 64'(s_payload), 64'(epay));
    cmp({tag, ".br_taken"}, 64'(branch_taken_e),
        64'(m[0].valid && m[0].br && cond_ok(m[0].cond, m_flags)));
    cmp({tag, ".flags"}, 64'(flags_q), 64'(m_flags));
    cmp({tag, ".pcw_inflight"}, 64'(pc_write_inflight),
        64'((d_pcs && d_valid) || (|ep[NSTG-2:0])));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clr_in();
    d_valid = 0; d_pcs = 0; d_regw = 0; d_memw = 0; d_memtoreg = 0;
    d_nowrite = 0; d_branch = 0; d_flagw = 0; d_cond = 4'd14; d_payload = '0;
    stall = '0; flush = '0;
  endtask

  task automatic put(bit [3:0] cond, bit regw, bit [1:0] fw, bit br, bit pcs, bit [PW-1:0] pay);
    d_valid = 1; d_cond = cond; d_regw = regw; d_flagw = fw;
    d_branch = br; d_pcs = pcs; d_payload = pay;
  endtask

  initial begin
    foreach (m[k]) m[k] = '{default: 0};
    m_flags = 4'b0000;
    clr_in();
    alu_flags = 4'b0000;
    reset = 1;
    tick("rst0");
    tick("rst1");
    cmp("rst_valid", 64'(s_valid), 64'd0);
    cmp("rst_flags", 64'(flags_q), 64'd0);
    reset = 0;

    // Basic latency: Decode to stage 0 in 1 cycle, stage 2 in 3 cycles.
    put(4'd14, 1, 2'b00, 0, 0, 12'hABC);
    tick("lat1");
    cmp("lat_regw0", 64'(s_regw[0]), 64'd1);
    clr_in();
    tick("lat2");
    tick("lat3");
    cmp("lat_regw2", 64'(s_regw[2]), 64'd1);
    cmp("lat_pay2", 64'(s_payload[2*PW +: PW]), 64'hABC);

    // Flag setting followed by EQ then NE consumers.
    put(4'd14, 0, 2'b11, 0, 0, 12'h101);
    tick("subs");
    alu_flags = 4'b0100;
    put(4'd0, 1, 2'b00, 0, 0, 12'h102);
    tick("eq");
    cmp("eq_flags", 64'(flags_q), 64'h4);
    cmp("eq_regw0", 64'(s_regw[0]), 64'd1);
    put(4'd1, 1, 2'b00, 0, 0, 12'h103);
    tick("ne");
    cmp("ne_regw0", 64'(s_regw[0]), 64'd0);
    cmp("ne_valid0", 64'(s_valid[0]), 64'd1);

    // Two-cycle stall of stage 0 with a flag-setting instruction held there.
    put(4'd14, 1, 2'b11, 0, 0, 12'h104);
    tick("st_load");
    alu_flags = 4'b1111;
    put(4'd14, 1, 2'b00, 0, 0, 12'h105);
    stall = 3'b001;
    tick("st1");
    tick("st2");
    cmp("st_hold0", 64'(s_payload[0 +: PW]), 64'h104);
    cmp("st_bubble1", 64'(s_valid[1]), 64'd0);
    cmp("st_flags", 64'(flags_q), 64'h4);
    clr_in();
    tick("st_rel");

    // Flush and stall together on a valid branch in stage 0.
    put(4'd14, 0, 2'b00, 1, 0, 12'h106);
    tick("br_load");
    cmp("br_taken", 64'(branch_taken_e), 64'd1);
    clr_in();
    flush = 3'b001; stall = 3'b001;
    tick("br_flush");
    cmp("brf_valid0", 64'(s_valid[0]), 64'd0);
    cmp("brf_taken", 64'(branch_taken_e), 64'd0);
    clr_in();

    // PC-write in-flight tracking, then a never-condition branch.
    put(4'd14, 0, 2'b00, 1, 1, 12'h107);
    #1;
    cmp("pcw_dec", 64'(pc_write_inflight), 64'd1);
    tick("pcw0");
    clr_in();
    #1;
    cmp("pcw_s0", 64'(pc_write_inflight), 64'd1);
    tick("pcw1");
    cmp("pcw_s1", 64'(pc_write_inflight), 64'd1);
    tick("pcw2");
    cmp("pcw_last", 64'(pc_write_inflight), 64'd0);
    put(4'd15, 0, 2'b00, 1, 1, 12'h108);
    tick("nv");
    cmp("nv_taken", 64'(branch_taken_e), 64'd0);
    clr_in();

    // Reset with a full pipeline of flag setters.
    alu_flags = 4'b1010;
    for (int i = 0; i < NSTG; i++) begin
      put(4'd14, 1, 2'b11, 0, 1, 12'h200 + 12'(i));
      tick("fill");
    end
    reset = 1;
    tick("rst_full");
    cmp("rf_valid", 64'(s_valid), 64'd0);
    cmp("rf_pay", 64'(s_payload), 64'd0);
    cmp("rf_flags", 64'(flags_q), 64'd0);
    reset = 0;
    clr_in();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      d_valid    = ($urandom_range(0, 3) != 0);
      d_pcs      = 1'($urandom_range(0, 1));
      d_regw     = 1'($urandom_range(0, 1));
      d_memw     = 1'($urandom_range(0, 1));
      d_memtoreg = 1'($urandom_range(0, 1));
      d_nowrite  = ($urandom_range(0, 3) == 0);
      d_branch   = 1'($urandom_range(0, 1));
      d_flagw    = 2'($urandom_range(0, 3));
      d_cond     = 4'($urandom_range(0, 15));
      d_payload  = PW'($urandom);
      alu_flags  = 4'($urandom_range(0, 15));
      for (int k = 0; k < NSTG; k++) begin
        stall[k] = ($urandom_range(0, 5) == 0);
        flush[k] = ($urandom_range(0, 9) == 0);
      end
      reset = ($urandom_range(0, 63) == 0);
      tick("rnd");
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_chain.md
PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 Parameter NSTG, default 3, number of registered stages after Decode (index 0 = Execute, last = Writeback); legal range 3..8.
REQ-002 Parameter PW, default 12, width of the opaque per-instruction payload (e.g. SPU code).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d_valid  input  1  Decode holds a real instruction.
REQ-006 d_pcs, d_regw, d_memw, d_memtoreg, d_nowrite, d_branch  input  1 each  decoded control bits.
REQ-007 d_flagw  input  2  flag-write enables: [1] updates N,Z; [0] updates C,V.
REQ-008 d_cond  input  4  condition field (instruction bits 31:28).
REQ-009 d_payload  input  PW  payload carried unchanged to every stage.
REQ-010 alu_flags  input  4  NZCV produced by the ALU for the Execute instruction ([3]=N .. [0]=V).
REQ-011 stall  input  NSTG  per-stage hold request; flush  input  NSTG  per-stage squash request.
REQ-012 s_valid, s_regw, s_memw, s_memtoreg, s_pcs  output  NSTG each  gated control per stage.
REQ-013 s_payload  output  NSTG x PW  packed payload per stage.
REQ-014 branch_taken_e  output  1  Execute holds a valid, condition-passing branch.
REQ-015 flags_q  output  4  architectural NZCV register.
REQ-016 pc_write_inflight  output  1  d_pcs&d_valid OR any s_pcs[k] for k < NSTG-1.

Function
REQ-017 Stage 0 captures the decode bundle; stage k>0 captures stage k-1; latency Decode to stage k is k+1 cycles.
REQ-018 Per stage priority on each edge: flush[k] -> valid cleared, all bits zero; else stall[k] -> contents held; else load from upstream.
REQ-019 If stage k-1 (or Decode for k=0) is stalled while stage k is not, stage k loads a bubble (valid=0, controls 0).
REQ-020 Stage 0 outputs: condition pass computed combinationally from stage-0 cond and flags_q; s_regw[0]=regw&pass&~nowrite&valid, s_memw[0]=memw&pass&valid, s_pcs[0]=pcs&pass&valid.
REQ-021 Stages k>=1 store the already-gated stage-0 outputs; s_memtoreg and payload pass ungated, valid-qualified.
REQ-022 Condition table: 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !C|Z, 10 GE N==V, 11 LT N!=V, 12 GT !Z&(N==V), 13 LE Z|(N!=V), 14 AL 1, 15 never (pass=0).
REQ-023 flags_q[3:2] <= alu_flags[3:2] when stage 0 valid, pass, flagw[1], and stage 0 not stalled and not flushed; flags_q[1:0] likewise with flagw[0].
REQ-024 Flag update and condition use are same-cycle: a flag-setting instruction affects only the next instruction reaching stage 0.
REQ-025 branch_taken_e = s_valid[0] & branch & pass.
REQ-026 A stalled stage 0 re-evaluates pass every cycle against current flags_q.
REQ-027 Simultaneous flush and stall on the same stage: flush wins.

Reset
REQ-028 On reset: all stage valid and control bits 0, payloads 0, flags_q = 4'b0000; all outputs 0 the cycle after reset asserts.
REQ-029 Reset overrides stall and flush; an instruction in flight during reset is discarded, no flag write.

Structure
REQ-030 Package pipe_ctrl_pkg holds the cond-code enum, NZCV bit-index constants and the packed stage-control struct.
REQ-031 One sub-module cond_check (cond, nzcv -> pass), purely combinational; no other hierarchy.

Verification
REQ-032 Reset then d_valid=1, d_regw=1, cond=AL, payload=0xABC -> s_regw[0] at cycle 1, s_regw[2] and s_payload[2]=0xABC at cycle 3.
REQ-033 SUBS with flagw=2'b11, alu_flags=0100, followed by cond=EQ regw -> flags_q=0100, second instruction s_regw[0]=1; repeat with cond=NE -> s_regw[0]=0, s_valid[0]=1.
REQ-034 stall[0]=1 for 2 cycles with instruction in stage 0 -> stage 0 held, stage 1 receives 2 bubbles, flags_q unchanged.
REQ-035 flush[0] and stall[0] together with valid branch in stage 0 -> next cycle s_valid[0]=0, branch_taken_e=0.
REQ-036 Branch cond=AL, d_pcs=1 -> pc_write_inflight=1 from decode until branch reaches last stage, then 0; cond=15 -> branch_taken_e=0.
REQ-037 Reset asserted with all stages valid and flagw set -> next cycle all outputs 0, flags_q=0.
